bin2bcd_seq: RTL and testbench

Parametrised sequential binary-to-BCD converter. It is the successor to the fixed 16-bit, three-divider BCD converter in the display path. It uses iterative shift-and-add-3 (double dabble), one bit per clock, instead of dividers. It adds:
- configurable input width, digit count and signed/unsigned mode;
- a valid/ready handshake on both sides;
- overflow detection with saturation.

It sits between the arithmetic core and the 7-segment display driver.

---
 rtl/bin2bcd_seq.sv | 140 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one input bit per clock,
// with valid/ready handshakes, optional sign nibble and saturating overflow.
module bin2bcd_seq #(
    parameter int W      = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              n,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*(DIGITS+1)-1:0]   bcd,
    output logic                      ovf
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [W-1:0]   mag;
    logic [W-1:0]   mag_nxt;
    logic [W-1:0]   n_abs;
    logic [DW-1:0]  dig;
    logic [DW-1:0]  dig_adj;
    logic [DW-1:0]  dig_nxt;
    logic [CW-1:0]  cnt;
    logic           neg;
    logic           neg_in;
    logic           ovf_int;
    logic           ovf_nxt;
    logic           accept;
    logic           last_iter;
    logic           release_out;

    // Negating in W bits maps the most negative value onto its own magnitude.
    always_comb begin
        neg_in = (SIGNED != 0) && n[W-1];
        n_abs  = neg_in ? -n : n;
    end

    // One double-dabble iteration; each nibble is adjusted without carry into
    // its neighbour, and the bit leaving the top digit marks overflow.
    always_comb begin
        dig_adj = dig;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (dig[4*i +: 4] >= 4'd5) begin
                dig_adj[4*i +: 4] = dig[4*i +: 4] + 4'd3;
            end
        end
        dig_nxt = {dig_adj[DW-2:0], mag[W-1]};
        mag_nxt = {mag[W-2:0], 1'b0};
        ovf_nxt = ovf_int | dig_adj[DW-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        last_iter   = 1'b0;
        release_out = 1'b0;
        in_ready    = (state == IDLE) && !rst;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (cnt == CW'(1)) begin
                    last_iter = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The result register is loaded from the final iteration's combinational
    // output so out_valid rises on the same edge as the last shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag       <= '0;
            dig       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            ovf_int   <= 1'b0;
            bcd       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                mag     <= n_abs;
                neg     <= neg_in;
                dig     <= '0;
                ovf_int <= 1'b0;
                cnt     <= CW'(W);
            end
            if (state == CONV) begin
                mag     <= mag_nxt;
                dig     <= dig_nxt;
                ovf_int <= ovf_nxt;
                cnt     <= cnt - CW'(1);
            end
            if (last_iter) begin
                bcd       <= {(neg ? 4'd5 : 4'd0), (ovf_nxt ? {DIGITS{4'd9}} : dig_nxt)};
                ovf       <= ovf_nxt;
                out_valid <= 1'b1;
            end
            if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: three configurations, hand-computed results,
// latency, backpressure and mid-conversion reset.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
    logic [15:0] a_n;
    logic [23:0] a_bcd;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
    logic [15:0] b_n;
    logic [23:0] b_bcd;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_ovf;
    logic [11:0] c_n;
    logic [15:0] c_bcd;

    int n_assert = 0;
    int n_fail   = 0;

    bin2bcd_seq #(.W(16), .DIGITS(5), .SIGNED(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .n(a_n),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .bcd(a_bcd), .ovf(a_ovf)
    );

    bin2bcd_seq #(.W(16), .DIGITS(5), .SIGNED(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .n(b_n),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .bcd(b_bcd), .ovf(b_ovf)
    );

    bin2bcd_seq #(.W(12), .DIGITS(3), .SIGNED(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .n(c_n),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .bcd(c_bcd), .ovf(c_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic conv_a(input logic [15:0] val, input logic [23:0] exp, input logic exp_ovf,
                          input string tag);
        int lat;
        check({tag, "_rdy"}, 32'(a_in_ready), 32'd1);
        a_n = val;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_n = ~val;
        check({tag, "_busy"}, 32'(a_in_ready), 32'd0);
        lat = 0;
        while (!a_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd16);
        check({tag, "_bcd"}, 32'(a_bcd), 32'(exp));
        check({tag, "_ovf"}, 32'(a_ovf), 32'(exp_ovf));
        if (a_out_ready) begin
            @(posedge clk); #1;
            check({tag, "_vld_drop"}, 32'(a_out_valid), 32'd0);
            check({tag, "_rdy_back"}, 32'(a_in_ready), 32'd1);
            check({tag, "_bcd_hold"}, 32'(a_bcd), 32'(exp));
        end
    endtask

    task automatic conv_b(input logic [15:0] val, input logic [23:0] exp, input string tag);
        int lat;
        b_n = val;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd16);
        check({tag, "_bcd"}, 32'(b_bcd), 32'(exp));
        check({tag, "_ovf"}, 32'(b_ovf), 32'd0);
        @(posedge clk); #1;
        check({tag, "_vld_drop"}, 32'(b_out_valid), 32'd0);
    endtask

    task automatic conv_c(input logic [11:0] val, input logic [15:0] exp, input logic exp_ovf,
                          input string tag);
        int lat;
        c_n = val;
        c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        lat = 0;
        while (!c_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd12);
        check({tag, "_bcd"}, 32'(c_bcd), 32'(exp));
        check({tag, "_ovf"}, 32'(c_ovf), 32'(exp_ovf));
        @(posedge clk); #1;
        check({tag, "_vld_drop"}, 32'(c_out_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_n = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_n = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_n = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_bcd", 32'(a_bcd), 32'd0);
        check("rst_ovf", 32'(a_ovf), 32'd0);
        check("rst_c_bcd", 32'(c_bcd), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 32'(a_in_ready), 32'd1);

        // Signed 16-bit, five digits
        conv_a(16'd1234, 24'h001234, 1'b0, "a_1234");
        conv_a(16'h8000, 24'h532768, 1'b0, "a_min");
        conv_a(16'hFFFF, 24'h500001, 1'b0, "a_m1");
        conv_a(16'h0000, 24'h000000, 1'b0, "a_zero");
        conv_a(16'h7FFF, 24'h032767, 1'b0, "a_max");
        conv_a(16'hFFD6, 24'h500042, 1'b0, "a_m42");

        // Backpressure: result held, new request ignored until released
        a_out_ready = 1'b0;
        conv_a(16'd321, 24'h000321, 1'b0, "bp");
        a_n = 16'd7;
        a_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(a_out_valid), 32'd1);
            check("bp_hold_bcd", 32'(a_bcd), 32'h000321);
            check("bp_hold_rdy", 32'(a_in_ready), 32'd0);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(a_out_valid), 32'd0);
        check("bp_release_rdy", 32'(a_in_ready), 32'd1);
        check("bp_release_bcd", 32'(a_bcd), 32'h000321);
        @(posedge clk); #1;
        check("bp_next_accepted", 32'(a_in_ready), 32'd0);
        a_in_valid = 1'b0;
        a_n = 16'd9;
        begin
            int lat = 0;
            while (!a_out_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            check("bp_next_lat", 32'(lat), 32'd16);
            check("bp_next_bcd", 32'(a_bcd), 32'h000007);
        end
        @(posedge clk); #1;
        check("bp_next_drop", 32'(a_out_valid), 32'd0);

        // Reset at iteration 8 aborts the conversion
        a_n = 16'd5555;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_valid", 32'(a_out_valid), 32'd0);
        check("abort_bcd", 32'(a_bcd), 32'd0);
        check("abort_ovf", 32'(a_ovf), 32'd0);
        check("abort_rdy_in_rst", 32'(a_in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_rdy_after", 32'(a_in_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("abort_no_result", 32'(a_out_valid), 32'd0);
        end
        conv_a(16'd42, 24'h000042, 1'b0, "post_rst");

        // Unsigned 16-bit: no sign nibble
        conv_b(16'hFFFF, 24'h065535, "b_ffff");
        conv_b(16'h8000, 24'h032768, "b_8000");
        conv_b(16'h0000, 24'h000000, "b_zero");

        // Unsigned 12-bit, three digits: saturation boundary
        conv_c(12'hFFF, 16'h0999, 1'b1, "c_4095");
        conv_c(12'h3E7, 16'h0999, 1'b0, "c_999");
        conv_c(12'h3E8, 16'h0999, 1'b1, "c_1000");
        conv_c(12'h1F4, 16'h0500, 1'b0, "c_500");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
